// File: rtl/clk_map_poller_if.sv
// Avalon-MM bus between clk_map_poller (master) and the clk_map PIO slave.
interface clk_map_poller_if;
   logic [1:0]  avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;
   logic        avm_readdatavalid;

   modport master (
      output avm_address, avm_read, avm_write, avm_writedata,
      input  avm_readdata, avm_waitrequest, avm_readdatavalid
   );

   modport slave (
      input  avm_address, avm_read, avm_write, avm_writedata,
      output avm_readdata, avm_waitrequest, avm_readdatavalid
   );
endinterface

// File: rtl/clk_map_poller.sv
// Polls the clk_map PIO edge-capture register, clears serviced edges, counts them and latches the input level.
// Optional read-response watchdog with sticky timeout_err: define CLK_MAP_POLLER_TIMEOUT_EN.
module clk_map_poller #(
   parameter int         POLL_INTERVAL = 1000,
   parameter int         CNT_W         = 32,
   parameter logic [1:0] EDGE_ADDR     = 2'd3,
   parameter logic [1:0] DATA_ADDR     = 2'd0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   clk_map_poller_if.master avm,
   output logic [CNT_W-1:0] event_count,
   output logic             level,
   output logic             event_pulse,
   output logic             busy
`ifdef CLK_MAP_POLLER_TIMEOUT_EN
   ,
   output logic             timeout_err
`endif
);

   localparam int            TW     = $clog2(POLL_INTERVAL);
   localparam logic [TW-1:0] RELOAD = TW'(POLL_INTERVAL - 1);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD_EDGE = 3'd1;
   localparam logic [2:0] WT_EDGE = 3'd2;
   localparam logic [2:0] WR_CLR  = 3'd3;
   localparam logic [2:0] RD_DATA = 3'd4;
   localparam logic [2:0] WT_DATA = 3'd5;

   logic [2:0]    state;
   logic [TW-1:0] timer;
   logic          wd_expire;

   // Only bit0 of either register is meaningful.
   logic unused_rd;
   assign unused_rd = ^avm.avm_readdata[31:1];

`ifdef CLK_MAP_POLLER_TIMEOUT_EN
   logic [7:0] wdog;
   logic       enable_q;
   logic       in_wt;

   assign in_wt = (state == WT_EDGE) || (state == WT_DATA);
   // wdog reads 254 during the 255th cycle spent waiting.
   assign wd_expire = in_wt && (wdog == 8'd254) && !avm.avm_readdatavalid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wdog        <= '0;
         enable_q    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         enable_q <= enable;
         wdog     <= (in_wt && !wd_expire) ? wdog + 8'd1 : 8'd0;
         if (enable && !enable_q)
            timeout_err <= 1'b0;
         else if (wd_expire)
            timeout_err <= 1'b1;
      end
   end
`else
   assign wd_expire = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         timer       <= RELOAD;
         event_count <= '0;
         level       <= 1'b0;
         event_pulse <= 1'b0;
      end else begin
         event_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (!enable)
                  timer <= RELOAD;
               else if (timer != '0)
                  timer <= timer - TW'(1);
               else begin
                  timer <= RELOAD;
                  state <= RD_EDGE;
               end
            end
            RD_EDGE: if (!avm.avm_waitrequest) state <= WT_EDGE;
            WT_EDGE: begin
               if (avm.avm_readdatavalid)
                  state <= avm.avm_readdata[0] ? WR_CLR : IDLE;
               else if (wd_expire) begin
                  timer <= RELOAD;
                  state <= IDLE;
               end
            end
            WR_CLR: begin
               if (!avm.avm_waitrequest) begin
                  event_count <= event_count + CNT_W'(1);
                  event_pulse <= 1'b1;
                  state       <= RD_DATA;
               end
            end
            RD_DATA: if (!avm.avm_waitrequest) state <= WT_DATA;
            WT_DATA: begin
               if (avm.avm_readdatavalid) begin
                  level <= avm.avm_readdata[0];
                  state <= IDLE;
               end else if (wd_expire) begin
                  timer <= RELOAD;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Requests decode straight from state so reset drops them without waiting for a clock.
   always_comb begin
      avm.avm_address   = '0;
      avm.avm_read      = 1'b0;
      avm.avm_write     = 1'b0;
      avm.avm_writedata = '0;
      case (state)
         RD_EDGE: begin
            avm.avm_read    = 1'b1;
            avm.avm_address = EDGE_ADDR;
         end
         WR_CLR: begin
            avm.avm_write     = 1'b1;
            avm.avm_address   = EDGE_ADDR;
            avm.avm_writedata = 32'h1;
         end
         RD_DATA: begin
            avm.avm_read    = 1'b1;
            avm.avm_address = DATA_ADDR;
         end
         default: ;
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_clk_map_poller.sv
// Randomized bench for clk_map_poller: TB-side Avalon slave plus an edge/level scoreboard.
module tb_clk_map_poller;
   localparam int P  = 4;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic [CW-1:0] event_count;
   logic          level, event_pulse, busy;
`ifdef CLK_MAP_POLLER_TIMEOUT_EN
   logic          timeout_err;
`endif

   clk_map_poller_if avm_if ();

   clk_map_poller #(.POLL_INTERVAL(P), .CNT_W(CW), .EDGE_ADDR(2'd3), .DATA_ADDR(2'd0)) dut (
      .clk(clk), .reset(reset), .enable(enable), .avm(avm_if),
      .event_count(event_count), .level(level), .event_pulse(event_pulse), .busy(busy)
`ifdef CLK_MAP_POLLER_TIMEOUT_EN
      , .timeout_err(timeout_err)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int exp_cnt = 0;
   logic exp_lvl = 1'b0;
   int n_events = 0;

   // bus-level monitors
   int both_err = 0, idle_bus_err = 0, pulse_cnt = 0, pulse_wide = 0, edge_reads = 0;
   logic pulse_prev = 1'b0, read_prev = 1'b0;

   always @(negedge clk) begin
      if (avm_if.avm_read && avm_if.avm_write) both_err <= both_err + 1;
      if (!avm_if.avm_read && !avm_if.avm_write &&
          (avm_if.avm_address != 2'd0 || avm_if.avm_writedata != 32'd0))
         idle_bus_err <= idle_bus_err + 1;
      if (event_pulse) pulse_cnt <= pulse_cnt + 1;
      if (event_pulse && pulse_prev) pulse_wide <= pulse_wide + 1;
      pulse_prev <= event_pulse;
      if (avm_if.avm_read && !read_prev && avm_if.avm_address == 2'd3) edge_reads <= edge_reads + 1;
      read_prev <= avm_if.avm_read;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Waits for a request, checks it, stalls it, accepts it once, and checks it is released.
   task automatic wait_req(input string tag, input logic exp_rd, input logic exp_wr,
                           input logic [1:0] exp_addr, input int stall, output int waited);
      logic [3:0] exp_bus;
      exp_bus = {exp_rd, exp_wr, exp_addr};
      waited = 0;
      while (!(avm_if.avm_read || avm_if.avm_write) && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!(avm_if.avm_read || avm_if.avm_write)) begin
         chk({tag, "_no_request"}, 32'd0, 32'd1);
         return;
      end
      chk({tag, "_req"}, 32'({avm_if.avm_read, avm_if.avm_write, avm_if.avm_address}), 32'(exp_bus));
      if (exp_wr) chk({tag, "_wdata"}, avm_if.avm_writedata, 32'h1);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk({tag, "_hold"}, 32'({avm_if.avm_read, avm_if.avm_write, avm_if.avm_address}), 32'(exp_bus));
         if (exp_wr) chk({tag, "_hold_wdata"}, avm_if.avm_writedata, 32'h1);
      end
      avm_if.avm_waitrequest = 1'b0;
      @(negedge clk);
      avm_if.avm_waitrequest = 1'b1;
      if (exp_wr) chk({tag, "_released"}, 32'(avm_if.avm_write), 32'd0);
      else        chk({tag, "_released"}, 32'(avm_if.avm_read), 32'd0);
   endtask

   task automatic give_data(input int lat, input logic [31:0] d);
      repeat (lat) @(negedge clk);
      avm_if.avm_readdatavalid = 1'b1;
      avm_if.avm_readdata      = d;
      @(negedge clk);
      avm_if.avm_readdatavalid = 1'b0;
      avm_if.avm_readdata      = $urandom;
   endtask

   // One poll: edge read, and when an edge is reported the clear write and level read.
   task automatic poll_seq(input logic edge_bit, input logic dval, input int st1, input int st2,
                           input int lat, input int exp_gap, input bit drop_en);
      int w;
      wait_req("rd_edge", 1'b1, 1'b0, 2'd3, st1, w);
      if (exp_gap >= 0) chk("poll_gap", 32'(w), 32'(exp_gap));
      chk("busy_wait", 32'(busy), 32'd1);
      if (drop_en) enable = 1'b0;
      give_data(lat, {31'($urandom), edge_bit});
      if (edge_bit) begin
         wait_req("wr_clr", 1'b0, 1'b1, 2'd3, st2, w);
         exp_cnt = (exp_cnt + 1) % (1 << CW);
         n_events++;
         chk("count_at_clear", 32'(event_count), 32'(exp_cnt));
         chk("pulse", 32'(event_pulse), 32'd1);
         wait_req("rd_data", 1'b1, 1'b0, 2'd0, st1, w);
         chk("rd_data_gap", 32'(w), 32'd0);
         give_data(lat, {31'($urandom), dval});
         exp_lvl = dval;
      end
      chk("idle_after", 32'(busy), 32'd0);
      chk("level", 32'(level), 32'(exp_lvl));
      chk("count", 32'(event_count), 32'(exp_cnt));
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int w, reads0;
      reset = 1'b1;
      enable = 1'b0;
      avm_if.avm_waitrequest   = 1'b1;
      avm_if.avm_readdatavalid = 1'b0;
      avm_if.avm_readdata      = '0;
      repeat (3) @(negedge clk);
      chk("rst_count", 32'(event_count), 32'd0);
      chk("rst_outs", 32'({level, event_pulse, busy, avm_if.avm_read, avm_if.avm_write}), 32'd0);
`ifdef CLK_MAP_POLLER_TIMEOUT_EN
      chk("rst_timeout_err", 32'(timeout_err), 32'd0);
`endif
      reset = 1'b0;
      @(negedge clk);

      // no edge reported, twice: read P cycles after enable, and P cycles after each return to idle
      enable = 1'b1;
      poll_seq(1'b0, 1'b0, 0, 0, 0, P, 1'b0);
      poll_seq(1'b0, 1'b0, 0, 0, 0, P, 1'b0);
      poll_seq(1'b1, 1'b1, 0, 0, 0, P, 1'b0);
      poll_seq(1'b1, 1'b0, 3, 3, 1, P, 1'b0);

      for (int i = 0; i < 10; i++)
         poll_seq(($urandom % 3) != 0, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), P, 1'b0);

      // enable dropped while waiting for the edge read data
      poll_seq(1'b1, ~exp_lvl, 0, 1, 2, P, 1'b1);
      reads0 = edge_reads;
      repeat (4 * P) @(negedge clk);
      chk("no_poll_disabled", 32'(edge_reads), 32'(reads0));

      // stray readdatavalid in idle is ignored
      avm_if.avm_readdatavalid = 1'b1;
      avm_if.avm_readdata      = {31'd0, ~exp_lvl};
      @(negedge clk);
      avm_if.avm_readdatavalid = 1'b0;
      @(negedge clk);
      chk("stray_rdv_busy", 32'(busy), 32'd0);
      chk("stray_rdv_level", 32'(level), 32'(exp_lvl));

      // reset while the clear write is pending
      enable = 1'b1;
      wait_req("rst_rd", 1'b1, 1'b0, 2'd3, 0, w);
      chk("rst_rd_gap", 32'(w), 32'(P));
      give_data(0, 32'h1);
      chk("wr_pending", 32'(avm_if.avm_write), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("rst_async_bus", 32'({avm_if.avm_read, avm_if.avm_write, avm_if.avm_address}), 32'd0);
      chk("rst_async_wdata", avm_if.avm_writedata, 32'd0);
      chk("rst_async_outs", 32'({event_count, level, event_pulse, busy}), 32'd0);
      enable = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      exp_cnt = 0;
      exp_lvl = 1'b0;
      @(negedge clk);

      // counter wrap: 1,2,3,0
      enable = 1'b1;
      for (int i = 0; i < 4; i++)
         poll_seq(1'b1, 1'(i), 0, $urandom_range(0, 2), 0, P, 1'b0);
      chk("wrapped", 32'(event_count), 32'd0);

`ifdef CLK_MAP_POLLER_TIMEOUT_EN
      begin
         int n;
         wait_req("to_rd", 1'b1, 1'b0, 2'd3, 0, w);
         n = 1;
         while (busy && n < 400) begin
            @(negedge clk);
            if (busy) n++;
         end
         enable = 1'b0;
         chk("wd_cycles", 32'(n), 32'd255);
         chk("timeout_err_set", 32'(timeout_err), 32'd1);
         chk("to_count", 32'(event_count), 32'(exp_cnt));
         chk("to_level", 32'(level), 32'(exp_lvl));
         @(negedge clk);
         chk("timeout_err_sticky", 32'(timeout_err), 32'd1);
         enable = 1'b1;
         @(negedge clk);
         chk("timeout_err_clear", 32'(timeout_err), 32'd0);
         enable = 1'b0;
         @(negedge clk);
      end
`else
      enable = 1'b0;
      @(negedge clk);
`endif

      @(negedge clk);
      chk("rd_wr_overlap", 32'(both_err), 32'd0);
      chk("idle_bus_zero", 32'(idle_bus_err), 32'd0);
      chk("pulse_width", 32'(pulse_wide), 32'd0);
      chk("pulse_total", 32'(pulse_cnt), 32'(n_events));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
